axi_rpack: RTL and testbench

AXI_RPACK -- requirements
Module: axi_rpack

---
 rtl/axi_rpack.sv | 131 +++++++++++++
 tb/tb_axi_rpack.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rpack.sv
// Packs RATIO narrow read words into one AXI R beat per descriptor beat, with
// an in-order {alen, aid} descriptor FIFO that supplies rid and rlast.
module axi_rpack #(
  parameter int AXI_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int REQID     = 4,
  parameter int DEPTH     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 avalid_i,
  output logic                 aready_o,
  input  logic [7:0]           alen_i,
  input  logic [REQID-1:0]     aid_i,
  input  logic                 dvalid_i,
  output logic                 dready_o,
  input  logic [OUT_WIDTH-1:0] ddata_i,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic                 rlast_o,
  output logic [REQID-1:0]     rid_o,
  output logic [AXI_WIDTH-1:0] rdata_o
);

  localparam int RATIO = AXI_WIDTH / OUT_WIDTH;
  localparam int PW    = $clog2(RATIO);
  localparam int AW    = $clog2(DEPTH);
  localparam int ISB   = REQID - 1;
  localparam logic [PW-1:0] P_LAST   = PW'(RATIO - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]   alen_mem [DEPTH];
  logic [ISB:0] aid_mem  [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic [PW-1:0]          p_reg;
  logic [7:0]             b_reg;
  logic [OUT_WIDTH-1:0]   lane_reg [RATIO-1];
  logic [AXI_WIDTH-1:0]   beat_next;
  logic                   rvalid_reg, rlast_reg;
  logic [ISB:0]           rid_reg;
  logic [AXI_WIDTH-1:0]   rdata_reg;

  logic         empty, push, pop, d_fire, beat_done, last_beat;
  logic [7:0]   head_alen;
  logic [ISB:0] head_aid;

  assign empty     = (count_reg == '0);
  assign aready_o  = (count_reg != FULL_CNT);
  assign head_alen = alen_mem[rd_ptr_reg];
  assign head_aid  = aid_mem[rd_ptr_reg];

  // The final word of a beat may only enter when the output register is free
  // or being drained in this same cycle.
  assign dready_o  = !empty && (p_reg != P_LAST || !rvalid_reg || rready_i);
  assign d_fire    = dvalid_i && dready_o;
  assign beat_done = d_fire && (p_reg == P_LAST);
  assign last_beat = (b_reg == head_alen);
  assign push      = avalid_i && aready_o;
  assign pop       = beat_done && last_beat;

  assign rvalid_o = rvalid_reg;
  assign rlast_o  = rlast_reg;
  assign rid_o    = rid_reg;
  assign rdata_o  = rdata_reg;

  always_ff @(posedge clock) begin
    if (push) begin
      alen_mem[wr_ptr_reg] <= alen_i;
      aid_mem[wr_ptr_reg]  <= aid_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Lower lanes are buffered; the top lane comes straight from the input.
  genvar gi;
  generate
    for (gi = 0; gi < RATIO - 1; gi++) begin : g_lane
      assign beat_next[gi*OUT_WIDTH +: OUT_WIDTH] = lane_reg[gi];
    end
  endgenerate
  assign beat_next[AXI_WIDTH-1 -: OUT_WIDTH] = ddata_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RATIO - 1; i++) lane_reg[i] <= '0;
    end else if (d_fire) begin
      for (int i = 0; i < RATIO - 1; i++)
        if (p_reg == PW'(i)) lane_reg[i] <= ddata_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_reg      <= '0;
      b_reg      <= '0;
      rvalid_reg <= 1'b0;
      rlast_reg  <= 1'b0;
      rid_reg    <= '0;
      rdata_reg  <= '0;
    end else begin
      if (d_fire) p_reg <= p_reg + 1'b1;
      if (beat_done) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= beat_next;
        rid_reg    <= head_aid;
        rlast_reg  <= last_beat;
        b_reg      <= last_beat ? 8'd0 : b_reg + 8'd1;
      end else if (rready_i) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_rpack.sv
// Directed and randomized checks of axi_rpack against a queue-based model of
// descriptors, accepted words and expected R beats.
module tb_axi_rpack;
  localparam int AXI_WIDTH = 32;
  localparam int OUT_WIDTH = 16;
  localparam int REQID     = 4;
  localparam int DEPTH     = 4;
  localparam int RATIO     = AXI_WIDTH / OUT_WIDTH;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic avalid_i = 1'b0, aready_o;
  logic [7:0] alen_i = '0;
  logic [REQID-1:0] aid_i = '0;
  logic dvalid_i = 1'b0, dready_o;
  logic [OUT_WIDTH-1:0] ddata_i = '0;
  logic rvalid_o, rready_i = 1'b0, rlast_o;
  logic [REQID-1:0] rid_o;
  logic [AXI_WIDTH-1:0] rdata_o;

  axi_rpack #(.AXI_WIDTH(AXI_WIDTH), .OUT_WIDTH(OUT_WIDTH), .REQID(REQID), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .avalid_i(avalid_i), .aready_o(aready_o), .alen_i(alen_i), .aid_i(aid_i),
    .dvalid_i(dvalid_i), .dready_o(dready_o), .ddata_i(ddata_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rlast_o(rlast_o),
    .rid_o(rid_o), .rdata_o(rdata_o)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] alen; logic [REQID-1:0] id; } desc_t;
  typedef struct { logic [AXI_WIDTH-1:0] data; logic [REQID-1:0] id; logic last; } beat_t;

  desc_t mdesc[$];
  beat_t exp_q[$];
  logic [OUT_WIDTH-1:0] wbuf[$];
  int mbeat = 0;
  int bt[$];
  int errors = 0, checks = 0, cyc = 0;
  bit acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input bit av, input logic [7:0] al, input logic [REQID-1:0] id,
                       input bit dv, input logic [OUT_WIDTH-1:0] dd, input bit rr, output bit a_acc);
    bit d_acc, r_acc, exp_dr;
    beat_t nb;
    @(posedge clock); #1;
    avalid_i = av; alen_i = al; aid_i = id; dvalid_i = dv; ddata_i = dd; rready_i = rr;
    @(negedge clock);
    cyc++;
    exp_dr = (mdesc.size() > 0) && (wbuf.size() != RATIO - 1 || exp_q.size() == 0 || rr);
    chk("aready", 64'(aready_o), 64'(mdesc.size() < DEPTH));
    chk("dready", 64'(dready_o), 64'(exp_dr));
    chk("rvalid", 64'(rvalid_o), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("rdata", 64'(rdata_o), 64'(exp_q[0].data));
      chk("rid",   64'(rid_o),   64'(exp_q[0].id));
      chk("rlast", 64'(rlast_o), 64'(exp_q[0].last));
    end
    a_acc = av && (mdesc.size() < DEPTH);
    d_acc = dv && exp_dr;
    r_acc = rr && (exp_q.size() > 0);
    if (r_acc) begin
      void'(exp_q.pop_front());
      bt.push_back(cyc);
    end
    if (d_acc) begin
      wbuf.push_back(dd);
      if (wbuf.size() == RATIO) begin
        nb.data = '0;
        for (int i = 0; i < RATIO; i++) nb.data[i*OUT_WIDTH +: OUT_WIDTH] = wbuf[i];
        nb.id   = mdesc[0].id;
        nb.last = (mbeat == int'(mdesc[0].alen));
        wbuf.delete();
        exp_q.push_back(nb);
        if (nb.last) begin
          void'(mdesc.pop_front());
          mbeat = 0;
        end else mbeat++;
      end
    end
    if (a_acc) mdesc.push_back('{al, id});
  endtask

  task automatic step(input bit av, input logic [7:0] al, input logic [REQID-1:0] id,
                      input bit dv, input logic [OUT_WIDTH-1:0] dd, input bit rr);
    cycle(av, al, id, dv, dd, rr, acc);
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 1'b1; avalid_i = 1'b0; dvalid_i = 1'b0; rready_i = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    mdesc.delete(); exp_q.delete(); wbuf.delete(); mbeat = 0;
    @(negedge clock);
    chk("rst_rvalid", 64'(rvalid_o), 64'(0));
    chk("rst_rlast",  64'(rlast_o),  64'(0));
    chk("rst_rid",    64'(rid_o),    64'(0));
    chk("rst_rdata",  64'(rdata_o),  64'(0));
    chk("rst_aready", 64'(aready_o), 64'(1));
    chk("rst_dready", 64'(dready_o), 64'(0));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((mdesc.size() > 0 || exp_q.size() > 0) && n < 2000) begin
      step(0, 0, 0, 1, 16'($urandom), 1);
      n++;
    end
    chk(tag, 64'(n < 2000), 64'(1));
  endtask

  task automatic chk_spacing(input string tag, input int n);
    chk({tag, "_beats"}, 64'(bt.size()), 64'(n));
    for (int i = 1; i < bt.size(); i++) chk({tag, "_gap"}, 64'(bt[i] - bt[i-1]), 64'(2));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pushed, n;
    logic [7:0] cur_al;
    logic [REQID-1:0] cur_id;
    bit av;

    apply_reset();

    // Single beat, fixed data.
    step(1, 0, 3, 0, 0, 1);
    step(0, 0, 0, 1, 16'h1111, 1);
    step(0, 0, 0, 1, 16'h2222, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t35_rvalid", 64'(rvalid_o), 64'(1));
    chk("t35_rdata",  64'(rdata_o),  64'(32'h2222_1111));
    chk("t35_rid",    64'(rid_o),    64'(3));
    chk("t35_rlast",  64'(rlast_o),  64'(1));
    step(0, 0, 0, 0, 0, 1);
    chk("t35_empty_aready", 64'(aready_o), 64'(1));
    chk("t35_empty_dready", 64'(dready_o), 64'(0));

    // Four-beat burst, back-to-back words.
    bt.delete();
    step(1, 3, 5, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 16'($urandom), 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk_spacing("t36", 4);

    // Backpressure on R with a beat pending.
    step(1, 1, 7, 0, 0, 0);
    step(0, 0, 0, 1, 16'hA001, 0);
    step(0, 0, 0, 1, 16'hA002, 0);
    step(0, 0, 0, 1, 16'hA003, 0);
    step(0, 0, 0, 1, 16'hA004, 0);
    chk("t38_dready_held", 64'(dready_o), 64'(0));
    step(0, 0, 0, 1, 16'hA004, 0);
    step(0, 0, 0, 1, 16'hA004, 1);
    chk("t38_dready_rel", 64'(dready_o), 64'(1));
    drain("t38_drain");

    // Fill the descriptor FIFO, then pop / push+pop around full.
    for (int i = 0; i < 4; i++) step(1, 0, 4'(8 + i), 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t37_full", 64'(aready_o), 64'(0));
    step(1, 0, 12, 1, 16'hB001, 1);
    step(1, 0, 12, 1, 16'hB002, 1);
    chk("t37_blocked", 64'(aready_o), 64'(0));
    step(0, 0, 0, 1, 16'hB003, 1);
    chk("t37_room", 64'(aready_o), 64'(1));
    step(1, 0, 12, 1, 16'hB004, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t37_pushpop", 64'(aready_o), 64'(1));
    step(1, 0, 13, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t37_refull", 64'(aready_o), 64'(0));
    drain("t37_drain");

    // Two transactions with a continuous stream across the boundary.
    bt.delete();
    step(1, 1, 1, 0, 0, 1);
    step(1, 0, 2, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 16'($urandom), 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk_spacing("t39", 3);

    // Reset in the middle of a beat.
    step(1, 0, 4, 0, 0, 1);
    step(0, 0, 0, 1, 16'hDEAD, 1);
    apply_reset();
    step(0, 0, 0, 1, 16'hBEEF, 1);
    step(1, 0, 6, 0, 0, 1);
    step(0, 0, 0, 1, 16'h3333, 1);
    step(0, 0, 0, 1, 16'h4444, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t40_rdata", 64'(rdata_o), 64'(32'h4444_3333));
    chk("t40_rid",   64'(rid_o),   64'(6));
    step(0, 0, 0, 0, 0, 1);

    // Random traffic, including one 256-beat burst.
    pushed = 0; n = 0;
    cur_al = 8'($urandom_range(0, 5));
    cur_id = REQID'($urandom);
    while ((pushed < 20 || mdesc.size() > 0 || exp_q.size() > 0) && n < 30000) begin
      av = (pushed < 20) && ($urandom_range(0, 1) == 1);
      cycle(av, cur_al, cur_id, $urandom_range(0, 3) != 0, 16'($urandom),
            $urandom_range(0, 3) != 0, acc);
      if (acc) begin
        pushed++;
        cur_al = (pushed == 10) ? 8'd255 : 8'($urandom_range(0, 5));
        cur_id = REQID'($urandom);
      end
      n++;
    end
    chk("rand_done", 64'(n < 30000), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
